// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Mul/div sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // ALU operand forward selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Forward select for one execute-stage source; MEM wins over WB because it is newer.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_m,
                                         input logic [4:0] wr_m,
                                         input logic       rw_w,
                                         input logic [4:0] wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
      sel = FWD_MEM;
    end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_seq.sv
// Multi-cycle multiply/divide sequencer: tracks latency and raises the stall/done flags.
module md_seq
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_e,
  input  logic md_is_div_e,
  input  logic dmem_wait,
  output logic md_busy,
  output logic md_done
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  // The start cycle and the DONE transition each account for one cycle of latency.
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);

  md_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          first_reg;
  logic          start_ok;

  // A start held off by a memory stall is simply not accepted this cycle.
  assign start_ok = md_start_e && !dmem_wait;

  // Next-state and counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = BUSY;
          cnt_next   = md_is_div_e ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        // The functional unit keeps running even while memory stalls the pipe.
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        if (!dmem_wait) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and first-cycle-of-DONE flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      first_reg <= (state_next == DONE) && (state_reg != DONE);
    end
  end

  // Busy covers the accepting cycle so the stall spans exactly the latency.
  always_comb begin
    md_busy = !rst && ((state_reg == BUSY) || ((state_reg == IDLE) && start_ok));
    md_done = !rst && (state_reg == DONE) && first_reg;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and mul/div stalls, branch flush.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] wr_e,
  input  logic [4:0] wr_m,
  input  logic [4:0] wr_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       pc_src_e,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic       dmem_wait,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       en_m,
  output logic       en_w,
  output logic       clr_d,
  output logic       clr_e,
  output logic       clr_m,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       md_busy,
  output logic       md_done
);

  logic [4:0] src_e [2];
  logic [1:0] fwd_e [2];
  logic       lw;
  // The execute-stage write flag is part of the stage bundle but no hazard rule needs it.
  logic       unused_regwrite_e;

  assign unused_regwrite_e = regwrite_e;
  assign src_e[0] = rs_e;
  assign src_e[1] = rt_e;

  // One forwarding comparator per ALU operand; forced to the regfile during reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd_e[gi] = rst ? FWD_RF : fwd_sel(src_e[gi], regwrite_m, wr_m, regwrite_w, wr_w);
    end
  end

  assign fwd_a_e = fwd_e[0];
  assign fwd_b_e = fwd_e[1];

  // Load in execute whose destination is read by the instruction in decode.
  assign lw = memtoreg_e && (wr_e != 5'd0) && ((wr_e == rs_d) || (wr_e == rt_d));

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .dmem_wait   (dmem_wait),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  // Prioritised enables/clears: reset > memory wait > mul/div > branch > load-use.
  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    if (rst) begin
      clr_d = 1'b1;
      clr_e = 1'b1;
      clr_m = 1'b1;
    end else if (dmem_wait) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (md_busy) begin
      // Freeze the front end and let older instructions drain behind a bubble.
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (pc_src_e) begin
      clr_d = 1'b1;
      clr_e = 1'b1;
    end else if (lw) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed mul/div sequences, random run.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, pc_src_e;
  logic       md_start_e, md_is_div_e, dmem_wait;
  logic       en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       md_busy, md_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the mul/div unit: cycles of stall still owed, and the done phase.
  int m_busy_left = 0;
  bit m_in_done   = 0;
  bit m_pulsed    = 0;

  logic [13:0] obs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wr_e(wr_e), .wr_m(wr_m), .wr_w(wr_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .pc_src_e(pc_src_e),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .dmem_wait(dmem_wait),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .md_busy(md_busy), .md_done(md_done)
  );

  // Packed view: {en f,d,e,m,w, clr d,e,m, fwd_a, fwd_b, busy, done}
  function automatic logic [13:0] dut_vec();
    return {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, fwd_a_e, fwd_b_e, md_busy, md_done};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (regwrite_m && wr_m != 0 && wr_m == src) return 2'd2;
    if (regwrite_w && wr_w != 0 && wr_w == src) return 2'd1;
    return 2'd0;
  endfunction

  // Expected outputs from the rules applied to current inputs and model state.
  function automatic logic [13:0] model_out();
    logic busy, done, lw;
    logic [4:0] en;
    logic [2:0] clr;
    if (rst) return {5'b11111, 3'b111, 2'd0, 2'd0, 1'b0, 1'b0};
    busy = (m_busy_left > 0) || (!m_in_done && md_start_e && !dmem_wait);
    done = m_in_done && !m_pulsed;
    lw   = memtoreg_e && wr_e != 0 && (wr_e == rs_d || wr_e == rt_d);
    en   = 5'b11111;
    clr  = 3'b000;
    if (dmem_wait)     en = 5'b00000;
    else if (busy)     begin en = 5'b00011; clr = 3'b001; end
    else if (pc_src_e) clr = 3'b110;
    else if (lw)       begin en = 5'b00111; clr = 3'b010; end
    return {en, clr, ref_fwd(rs_e), ref_fwd(rt_e), busy, done};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy_left = 0; m_in_done = 0; m_pulsed = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin m_in_done = 1; m_pulsed = 0; end
    end else if (m_in_done) begin
      m_pulsed = 1;
      if (!dmem_wait) m_in_done = 0;
    end else if (md_start_e && !dmem_wait) begin
      m_busy_left = (md_is_div_e ? DIV_N : MUL_N) - 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    obs = dut_vec();
    chk(tag, {18'd0, obs}, {18'd0, model_out()});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0; pc_src_e = 0;
    md_start_e = 0; md_is_div_e = 0; dmem_wait = 0;
  endtask

  // Issue one mul/div at cycle 0 and observe busy/done timing over ncyc cycles.
  task automatic run_md(input string tag, input bit is_div, input int ncyc,
                        input int wait_from, input int wait_to, input int rst_at,
                        output int busy_cnt, output int done_at, output int done_cnt);
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    quiet();
    for (int i = 0; i < ncyc; i++) begin
      md_start_e  = (i == 0);
      md_is_div_e = is_div;
      dmem_wait   = (i >= wait_from) && (i <= wait_to);
      rst         = (i == rst_at);
      cycle($sformatf("%s_c%0d", tag, i));
      if (obs[1]) busy_cnt++;
      if (obs[0]) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (dmem_wait) chk($sformatf("%s_wait_en_c%0d", tag, i), {27'd0, obs[13:9]}, 32'd0);
    end
    rst = 0;
    quiet();
    $display("seq %s: busy=%0d done_at=%0d done_pulses=%0d", tag, busy_cnt, done_at, done_cnt);
  endtask

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_m, rw_w, mtr, pcs, dw, rs;
    logic [1:0] fa, fb;
    logic [4:0] en;
    logic [2:0] clr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int bc, da, dc;
    rst = 1;
    quiet();

    // Combinational vectors with the mul/div unit idle: forwarding and priority.
    //          rs_d rt_d rs_e rt_e wr_e wr_m wr_w rwm rww mtr pcs dw rs  fa fb en        clr
    tbl[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 2'd2, 2'd0, 5'b11111, 3'b000};
    tbl[1]  = '{0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 2'd1, 2'd0, 5'b11111, 3'b000};
    tbl[2]  = '{0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    tbl[3]  = '{0, 0, 9, 9, 0, 9, 9, 0, 1, 0, 0, 0, 0, 2'd1, 2'd1, 5'b11111, 3'b000};
    tbl[4]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00111, 3'b010};
    tbl[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 5'b11111, 3'b110};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    tbl[7]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00111, 3'b010};
    tbl[8]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 2'd0, 5'b00000, 3'b000};
    tbl[9]  = '{0, 0, 5, 0, 0, 5, 0, 1, 0, 0, 1, 0, 1, 2'd0, 2'd0, 5'b11111, 3'b111};
    tbl[10] = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 5'b11111, 3'b110};
    tbl[12] = '{0, 0, 2, 2, 0, 2, 2, 1, 1, 0, 0, 1, 0, 2'd2, 2'd2, 5'b00000, 3'b000};

    // Reset state.
    @(posedge clk); #1;
    cycle("reset0");
    cycle("reset1");
    rst = 0;
    cycle("post_reset_idle");

    for (int i = 0; i < 13; i++) begin
      quiet();
      rs_d = tbl[i].rs_d; rt_d = tbl[i].rt_d; rs_e = tbl[i].rs_e; rt_e = tbl[i].rt_e;
      wr_e = tbl[i].wr_e; wr_m = tbl[i].wr_m; wr_w = tbl[i].wr_w;
      regwrite_m = tbl[i].rw_m; regwrite_w = tbl[i].rw_w; memtoreg_e = tbl[i].mtr;
      pc_src_e = tbl[i].pcs; dmem_wait = tbl[i].dw; rst = tbl[i].rs;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_a", i), {30'd0, fwd_a_e}, {30'd0, tbl[i].fa});
      chk($sformatf("vec%0d_fwd_b", i), {30'd0, fwd_b_e}, {30'd0, tbl[i].fb});
      chk($sformatf("vec%0d_en", i), {27'd0, en_f, en_d, en_e, en_m, en_w}, {27'd0, tbl[i].en});
      chk($sformatf("vec%0d_clr", i), {29'd0, clr_d, clr_e, clr_m}, {29'd0, tbl[i].clr});
      $display("vec %0d: fwd=%b/%b en=%b clr=%b", i, fwd_a_e, fwd_b_e,
               {en_f, en_d, en_e, en_m, en_w}, {clr_d, clr_e, clr_m});
      @(posedge clk);
      model_step();
      #1;
    end
    rst = 0;
    quiet();
    cycle("settle");

    // Divide and multiply latency.
    run_md("div", 1'b1, 40, -1, -1, -1, bc, da, dc);
    chk("div_busy_cycles", bc, DIV_N);
    chk("div_done_at", da, DIV_N);
    chk("div_done_pulses", dc, 1);

    run_md("mul", 1'b0, 8, -1, -1, -1, bc, da, dc);
    chk("mul_busy_cycles", bc, MUL_N);
    chk("mul_done_at", da, MUL_N);
    chk("mul_done_pulses", dc, 1);

    // Memory stall in mid-divide does not delay completion.
    run_md("div_wait_mid", 1'b1, 40, 10, 12, -1, bc, da, dc);
    chk("div_wait_mid_busy", bc, DIV_N);
    chk("div_wait_mid_done_at", da, DIV_N);
    chk("div_wait_mid_pulses", dc, 1);

    // Memory stall across completion holds DONE but pulses once.
    run_md("div_wait_done", 1'b1, 45, 31, 35, -1, bc, da, dc);
    chk("div_wait_done_busy", bc, DIV_N);
    chk("div_wait_done_done_at", da, DIV_N);
    chk("div_wait_done_pulses", dc, 1);

    // Reset in mid-divide abandons the operation.
    run_md("div_rst", 1'b1, 40, -1, -1, 10, bc, da, dc);
    chk("div_rst_busy", bc, 10);
    chk("div_rst_pulses", dc, 0);

    // Randomised run with small register numbers so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      wr_e = 5'($urandom_range(0, 3)); wr_m = 5'($urandom_range(0, 3));
      wr_w = 5'($urandom_range(0, 3));
      regwrite_e  = 1'($urandom_range(0, 1));
      regwrite_m  = 1'($urandom_range(0, 1));
      regwrite_w  = 1'($urandom_range(0, 1));
      memtoreg_e  = ($urandom_range(0, 2) == 0);
      pc_src_e    = ($urandom_range(0, 4) == 0);
      md_start_e  = ($urandom_range(0, 7) == 0);
      md_is_div_e = 1'($urandom_range(0, 1));
      dmem_wait   = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      cycle($sformatf("rand%0d", i));
      if (i % 500 == 499) $display("random batch ending at cycle %0d checked", i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES SHALL be: default 4; multiply latency in cycles, legal range >= 2.
REQ-002 Parameter DIV_CYCLES SHALL be: default 32; divide latency in cycles, legal range >= 2.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 rs_d, rt_d  in  5 each  SHALL be the decode-stage source register numbers.
REQ-006 rs_e, rt_e, wr_e  in  5 each  SHALL be the execute-stage sources and execute-stage destination.
REQ-007 wr_m, wr_w  in  5 each  SHALL be the memory-stage and writeback-stage destinations.
REQ-008 regwrite_e, regwrite_m, regwrite_w  in  1 each  SHALL be the per-stage register-write flags.
REQ-009 memtoreg_e  in  1  SHALL flag a load in execute.
REQ-010 pc_src_e  in  1  SHALL flag a taken branch or jump resolved in execute.
REQ-011 md_start_e, md_is_div_e  in  1 each  SHALL flag a mul/div in execute (1 = divide).
REQ-012 dmem_wait  in  1  SHALL flag that data memory is not ready.
REQ-013 en_f, en_d, en_e, en_m, en_w  out  1 each  SHALL be the PC and pipeline-register enables.
REQ-014 clr_d, clr_e, clr_m  out  1 each  SHALL be the IF/ID, ID/EX and EX/MEM synchronous clears (bubble insert).
REQ-015 fwd_a_e, fwd_b_e  out  2 each  SHALL be the ALU operand forward selects (00 regfile, 01 WB, 10 MEM).
REQ-016 md_busy, md_done  out  1 each  SHALL be the mul/div stall indicator and the one-cycle completion pulse.

Function
REQ-017 Forwarding SHALL be combinational: fwd_a_e=10 if regwrite_m && wr_m!=0 && wr_m==rs_e; else 01 if regwrite_w && wr_w!=0 && wr_w==rs_e; else 00. fwd_b_e SHALL use the same rule with rt_e.
REQ-018 Load-use stall lw SHALL be: memtoreg_e && wr_e!=0 && (wr_e==rs_d || wr_e==rt_d).
REQ-019 The mul/div FSM SHALL have states IDLE, BUSY and DONE, with a down-counter cnt of width clog2(DIV_CYCLES).
REQ-020 IDLE->BUSY SHALL occur when md_start_e && !dmem_wait; cnt SHALL load (md_is_div_e ? DIV_CYCLES : MUL_CYCLES)-2.
REQ-021 In BUSY, cnt SHALL decrement every cycle regardless of dmem_wait; at cnt==0 the FSM SHALL go BUSY->DONE.
REQ-022 DONE->IDLE SHALL occur when !dmem_wait; DONE SHALL hold while dmem_wait; md_start_e SHALL be ignored in BUSY and DONE.
REQ-023 md_busy SHALL be (state==BUSY) || (state==IDLE && md_start_e && !dmem_wait); stall therefore lasts exactly N cycles for latency N.
REQ-024 md_done SHALL be 1 only in the first cycle of DONE.
REQ-025 Output priority SHALL be: dmem_wait > md_busy > pc_src_e > lw.
REQ-026 dmem_wait=1: all en_*=0 and all clr_*=0.
REQ-027 md_busy=1: en_f=en_d=en_e=0, clr_m=1, en_m=en_w=1, and pc_src_e and lw ignored.
REQ-028 pc_src_e=1: clr_d=clr_e=1 and all en=1; a simultaneous lw SHALL be ignored.
REQ-029 lw=1: en_f=en_d=0, clr_e=1, remaining en=1.
REQ-030 Otherwise all en SHALL be 1 and all clr SHALL be 0.
REQ-031 Every output SHALL be combinational from inputs and state; the block SHALL add no pipeline latency.

Reset
REQ-032 On rst at posedge clk, state SHALL become IDLE and cnt SHALL become 0.
REQ-033 While rst=1, outputs SHALL be: all en=1, clr_d=clr_e=clr_m=1, fwd=00, md_busy=0, md_done=0.
REQ-034 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation with no md_done pulse.

Structure
REQ-035 A shared package SHALL hold the md_state_t enum (IDLE, BUSY, DONE) and the FWD_RF/FWD_WB/FWD_MEM constants.
REQ-036 The mul/div FSM and counter SHALL be the sub-module md_seq; forwarding and priority logic SHALL be top-level.

Verification
REQ-037 rs_e=5, wr_m=5, regwrite_m=1, wr_w=5, regwrite_w=1 -> fwd_a_e=10; wr_m=0 -> fwd_a_e=01; wr_w=0 as well -> 00.
REQ-038 memtoreg_e=1, wr_e=7, rt_d=7 -> en_f=en_d=0 and clr_e=1 for one cycle; with pc_src_e=1 added -> clr_d=clr_e=1 and en_f=1.
REQ-039 md_start_e with md_is_div_e=1 at cycle t -> md_busy=1 for cycles t..t+31, md_done=1 at t+32; multiply -> md_busy for 4 cycles.
REQ-040 dmem_wait=1 for 3 cycles in mid-divide -> all en=0 during those cycles, divide still completes at t+32; dmem_wait held at DONE -> DONE holds, md_done pulses once.
REQ-041 rst at t+10 of a divide -> state IDLE next cycle, no md_done, md_busy=0 unless md_start_e is reasserted.
